io_controller: RTL

//  Parametrised I/O port for the single-cycle processor. Writes processor data to N_OUT

---
 rtl/io_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/io_controller.sv
// ============================================================================
//  Module   : io_controller
//  Purpose  : I/O port for the single-cycle core. It drives N_OUT latched output
//             channels and serves input reads with a debounced confirm button.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_controller #(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 16,
    parameter int N_OUT        = 2,
    parameter int OUT_SEL_W    = 1,
    parameter int DEBOUNCE_CYC = 4,
    parameter int SIGN_EXT     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SW_W-1:0]         switches,
    input  logic                    btn_confirm,
    input  logic [DATA_W-1:0]       data_output,
    input  logic                    io_wr,
    input  logic [OUT_SEL_W-1:0]    out_sel,
    input  logic                    io_rd,
    output logic [N_OUT*DATA_W-1:0] saida,
    output logic [DATA_W-1:0]       es,
    output logic                    es_valid,
    output logic                    stall
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_RELEASE = 2'd2;

    logic               r_btn_meta;
    logic               r_btn_s;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_cnt_done;
    logic               w_counting;
    logic               w_capture;
    logic [DATA_W-1:0]  w_ext;
    logic [DATA_W-1:0]  r_es;
    logic               r_es_valid;

    // ------------------------------------------------------------------
    // Output channels: one register per channel, unmatched selects drop
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        logic [DATA_W-1:0] r_chan;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_chan <= '0;
            end else if (io_wr && (out_sel == OUT_SEL_W'(i))) begin
                r_chan <= data_output;
            end
        end

        assign saida[i*DATA_W +: DATA_W] = r_chan;
    end

    if (SIGN_EXT != 0) begin : g_sext
        assign w_ext = DATA_W'($signed(switches));
    end else begin : g_zext
        assign w_ext = DATA_W'(switches);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= btn_confirm;
            r_btn_s    <= r_btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Input FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_es       <= '0;
            r_es_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_es_valid <= w_capture;
            if (w_capture) begin
                r_es <= w_ext;
            end
        end
    end

    assign w_cnt_done = (r_cnt == c_CNT_LAST);

    // Next-state logic; an abort while waiting for the press wins over a capture
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (io_rd) w_state_next = c_ST_WAIT_PRESS;
            end
            c_ST_WAIT_PRESS: begin
                if (!io_rd)                     w_state_next = c_ST_IDLE;
                else if (r_btn_s && w_cnt_done) w_state_next = c_ST_WAIT_RELEASE;
            end
            c_ST_WAIT_RELEASE: begin
                if (!r_btn_s && w_cnt_done) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic: capture strobe and the debounce counter update
    always_comb begin
        w_capture  = (r_state == c_ST_WAIT_PRESS) && io_rd && r_btn_s && w_cnt_done;
        w_counting = ((r_state == c_ST_WAIT_PRESS)   &&  r_btn_s) ||
                     ((r_state == c_ST_WAIT_RELEASE) && !r_btn_s);
        w_cnt_next = '0;
        if (w_state_next == r_state && w_counting) begin
            w_cnt_next = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);
        end
    end

    assign es       = r_es;
    assign es_valid = r_es_valid;
    assign stall    = io_rd & ~r_es_valid;

endmodule

`default_nettype wire
